// File: rtl/scene_pkg.sv
// Shared types and constants for the scene loader and its record assembler.
package scene_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_PAYLOAD,
    S_CHECK
  } loader_state_t;

  localparam logic [7:0] MAGIC           = 8'hA5;
  localparam int         DATA_W_DEF      = 216;
  localparam int         TRI_BYTES       = DATA_W_DEF / 8;
  localparam int         TIMEOUT_CYC_DEF = 1_000_000;
  localparam int         TO_W            = $clog2(TIMEOUT_CYC_DEF + 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_COUNT   = 2'd1;
  localparam logic [1:0] ERR_CKSUM   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Idle-counter width for an arbitrary timeout limit.
  function automatic int to_width(input int cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/tri_assembler.sv
// Packs payload bytes little-endian into one triangle record and keeps the
// running XOR of every payload byte in the current packet.
module tri_assembler
  import scene_pkg::*;
#(
  parameter int DATA_W = TRI_BYTES * 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              byte_v_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] rec_o,
  output logic              rec_done_o,
  output logic [7:0]        xor_o
);

  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(NB);

  logic [IW-1:0]       idx_q;
  logic [DATA_W-9:0]   lanes_q;   // top lane is taken straight from the final byte
  logic [7:0]          xor_q;

  assign rec_done_o = byte_v_i && (idx_q == IW'(NB - 1));
  assign rec_o      = {byte_i, lanes_q};
  assign xor_o      = xor_q;

  // Byte index, lane capture and checksum accumulation on every accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      lanes_q <= '0;
      xor_q   <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
      xor_q <= '0;
    end else if (byte_v_i) begin
      xor_q <= xor_q ^ byte_i;
      idx_q <= rec_done_o ? '0 : idx_q + IW'(1);
      for (int k = 0; k < NB - 1; k++) begin
        if (idx_q == IW'(k)) lanes_q[k*8 +: 8] <= byte_i;
      end
    end
  end

endmodule

// File: rtl/scene_loader.sv
// Framed byte-stream parser that writes triangle records into scene memory,
// verifies the packet checksum and publishes the committed triangle count.
module scene_loader #(
  parameter int         DATA_W      = scene_pkg::TRI_BYTES * 8,
  parameter int         ADDR_W      = 12,
  parameter int         TIMEOUT_CYC = scene_pkg::TIMEOUT_CYC_DEF,
  parameter logic [7:0] MAGIC       = scene_pkg::MAGIC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wen,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] wsize,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  import scene_pkg::loader_state_t;
  import scene_pkg::S_IDLE;
  import scene_pkg::S_CNT_LO;
  import scene_pkg::S_CNT_HI;
  import scene_pkg::S_PAYLOAD;
  import scene_pkg::S_CHECK;
  import scene_pkg::ERR_COUNT;
  import scene_pkg::ERR_CKSUM;
  import scene_pkg::ERR_TIMEOUT;

  localparam int TW = scene_pkg::to_width(TIMEOUT_CYC);

  loader_state_t     state_q;
  logic [7:0]        cnt_lo_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic [ADDR_W-1:0] rec_idx_q;
  logic [TW-1:0]     to_q;
  logic              in_ready_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] wsize_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic              acc;
  logic              timeout_hit;
  logic [DATA_W-1:0] asm_rec;
  logic              asm_done;
  logic [7:0]        asm_xor;

  assign acc         = in_valid && in_ready_q;
  assign cnt_d       = ADDR_W'({in_data[3:0], cnt_lo_q});
  // An accepted byte on the limit cycle keeps the packet alive.
  assign timeout_hit = (state_q != S_IDLE) && !acc && (to_q == TW'(TIMEOUT_CYC - 1));

  tri_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (acc && (state_q == S_IDLE)),
    .byte_v_i   (acc && (state_q == S_PAYLOAD)),
    .byte_i     (in_data),
    .rec_o      (asm_rec),
    .rec_done_o (asm_done),
    .xor_o      (asm_xor)
  );

  // Packet FSM with registered memory-write, status and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_lo_q   <= '0;
      cnt_q      <= '0;
      rec_idx_q  <= '0;
      to_q       <= '0;
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      wsize_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      in_ready_q <= 1'b1;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (state_q == S_IDLE || acc) to_q <= '0;
      else                          to_q <= to_q + TW'(1);

      if (timeout_hit) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state_q    <= S_IDLE;
      end else if (acc) begin
        case (state_q)
          S_IDLE: if (in_data == MAGIC) state_q <= S_CNT_LO;
          S_CNT_LO: begin
            cnt_lo_q <= in_data;
            state_q  <= S_CNT_HI;
          end
          S_CNT_HI: begin
            if (in_data[7:4] != 4'd0) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_COUNT;
              state_q    <= S_IDLE;
            end else begin
              // Hide the old scene while its records are being overwritten.
              cnt_q     <= cnt_d;
              wsize_q   <= '0;
              rec_idx_q <= '0;
              state_q   <= (cnt_d == '0) ? S_CHECK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (asm_done) begin
              wen_q     <= 1'b1;
              wdata_q   <= asm_rec;
              waddr_q   <= rec_idx_q;
              rec_idx_q <= rec_idx_q + ADDR_W'(1);
              if (rec_idx_q + ADDR_W'(1) == cnt_q) state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (in_data == asm_xor) begin
              wsize_q <= cnt_q;
              done_q  <= 1'b1;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CKSUM;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign wen      = wen_q;
  assign wdata    = wdata_q;
  assign waddr    = waddr_q;
  assign wsize    = wsize_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_scene_loader.sv
// Directed bench for scene_loader: table of whole packets plus hand-written
// sequences for overflow, timeout, limit-cycle byte, gapped burst and reset.
module tb_scene_loader;

  localparam int DW = 216;
  localparam int AW = 12;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, wen, busy, done, err;
  logic [DW-1:0] wdata;
  logic [AW-1:0] waddr, wsize;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  scene_loader #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO), .MAGIC(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wen(wen), .wdata(wdata), .waddr(waddr), .wsize(wsize),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Monitor: every wen cycle is logged; done/err pulses are counted.
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int n_done = 0;
  int n_err = 0;
  always @(negedge clk) begin
    if (wen) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
    if (done) n_done++;
    if (err)  n_err++;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; presents one byte across exactly one rising edge.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hA5;   // junk on the bus while invalid
  endtask

  task automatic pause(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Whole packet; payload byte i = seed + i. stall_at/stall_len inserts one long gap.
  task automatic send_pkt(input int cnt, input logic [7:0] seed, input bit bad,
                          input int gap, input bit rnd, input int stall_at, input int stall_len);
    logic [7:0] ck;
    logic [7:0] b;
    ck = 8'h00;
    send(8'hA5);
    send(cnt[7:0]);
    send(cnt[15:8]);
    for (int i = 0; i < cnt * 27; i++) begin
      b  = seed + i[7:0];
      ck = ck ^ b;
      send(b);
      if (i == stall_at) pause(stall_len);
      pause(rnd ? int'($urandom_range(0, 3)) : gap);
    end
    send(bad ? ck ^ 8'hFF : ck);
    pause(3);
  endtask

  typedef struct {
    int         cnt;
    logic [7:0] seed;
    bit         bad;
    int         gap;
    int         e_wen;
    int         e_done;
    int         e_err;
    logic [1:0] e_code;
    logic [AW-1:0] e_wsize;
    logic [7:0] e_b0;
    logic [7:0] e_b26;
  } vec_t;

  vec_t tv[5];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int bw, bd, be, lat;
    tv[0] = '{1, 8'h01, 1'b0, 0, 1, 1, 0, 2'd0, 12'd1, 8'h01, 8'h1B};
    tv[1] = '{1, 8'h01, 1'b1, 0, 1, 0, 1, 2'd2, 12'd0, 8'h01, 8'h1B};
    tv[2] = '{0, 8'h00, 1'b0, 0, 0, 1, 0, 2'd0, 12'd0, 8'h00, 8'h00};
    tv[3] = '{2, 8'h90, 1'b0, 2, 2, 1, 0, 2'd0, 12'd2, 8'h90, 8'hAA};  // 0xA5 inside payload
    tv[4] = '{1, 8'hE0, 1'b0, 0, 1, 1, 0, 2'd0, 12'd1, 8'hE0, 8'hFA};

    // Reset state
    pause(3);
    chk("rst_in_ready", DW'(in_ready), 0);
    chk("rst_wen", DW'(wen), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_waddr", DW'(waddr), 0);
    chk("rst_wsize", DW'(wsize), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_err", DW'(err), 0);
    chk("rst_err_code", DW'(err_code), 0);
    reset = 1'b0;
    pause(1);
    chk("in_ready_rise", DW'(in_ready), 1);

    // Table of whole packets
    for (int v = 0; v < 5; v++) begin
      bw = wa_q.size(); bd = n_done; be = n_err;
      send_pkt(tv[v].cnt, tv[v].seed, tv[v].bad, tv[v].gap, 1'b0, -1, 0);
      chk($sformatf("v%0d_wen_count", v), DW'(wa_q.size() - bw), DW'(tv[v].e_wen));
      chk($sformatf("v%0d_done", v), DW'(n_done - bd), DW'(tv[v].e_done));
      chk($sformatf("v%0d_err", v), DW'(n_err - be), DW'(tv[v].e_err));
      if (tv[v].e_err != 0) chk($sformatf("v%0d_err_code", v), DW'(err_code), DW'(tv[v].e_code));
      chk($sformatf("v%0d_wsize", v), DW'(wsize), DW'(tv[v].e_wsize));
      chk($sformatf("v%0d_busy", v), DW'(busy), 0);
      if (wa_q.size() - bw == tv[v].e_wen) begin
        for (int r = 0; r < tv[v].e_wen; r++)
          chk($sformatf("v%0d_waddr%0d", v, r), DW'(wa_q[bw + r]), DW'(r));
        if (tv[v].e_wen > 0) begin
          chk($sformatf("v%0d_b0", v), DW'(wd_q[bw][7:0]), DW'(tv[v].e_b0));
          chk($sformatf("v%0d_b26", v), DW'(wd_q[bw][215:208]), DW'(tv[v].e_b26));
        end
      end
    end
    chk("err_code_hold", DW'(err_code), 2);

    // Count overflow keeps the published size
    bw = wa_q.size(); bd = n_done; be = n_err;
    send(8'hA5); send(8'h00); send(8'h10); pause(2);
    chk("ovf_err", DW'(n_err - be), 1);
    chk("ovf_code", DW'(err_code), 1);
    chk("ovf_wsize", DW'(wsize), 1);
    chk("ovf_wen", DW'(wa_q.size() - bw), 0);
    chk("ovf_done", DW'(n_done - bd), 0);
    chk("ovf_busy", DW'(busy), 0);

    // Timeout before the count completes leaves wsize alone
    be = n_err;
    send(8'hA5); send(8'h01); pause(20);
    chk("to_early_err", DW'(n_err - be), 1);
    chk("to_early_code", DW'(err_code), 3);
    chk("to_early_wsize", DW'(wsize), 1);

    // Timeout inside payload: err exactly TO cycles after the 10th byte
    bw = wa_q.size(); be = n_err;
    send(8'hA5); send(8'h01); send(8'h00);
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (err && lat == 0) lat = k;
    end
    chk("to_latency", DW'(lat), DW'(TO));
    chk("to_err_count", DW'(n_err - be), 1);
    chk("to_code", DW'(err_code), 3);
    chk("to_wsize", DW'(wsize), 0);
    chk("to_wen", DW'(wa_q.size() - bw), 0);
    chk("to_busy", DW'(busy), 0);
    bd = n_done;
    send_pkt(1, 8'h01, 1'b0, 0, 1'b0, -1, 0);
    chk("after_to_done", DW'(n_done - bd), 1);
    chk("after_to_wsize", DW'(wsize), 1);

    // Byte on the limit cycle wins over the timeout
    bd = n_done; be = n_err;
    send_pkt(1, 8'h10, 1'b0, 0, 1'b0, 4, TO - 1);
    chk("limit_err", DW'(n_err - be), 0);
    chk("limit_done", DW'(n_done - bd), 1);
    chk("limit_wsize", DW'(wsize), 1);

    // Garbage then a 3-record packet with random valid gaps
    send(8'h00); send(8'h5A); send(8'hFF);
    bw = wa_q.size(); bd = n_done; be = n_err;
    send_pkt(3, 8'h20, 1'b0, 0, 1'b1, -1, 0);
    chk("burst_wen_count", DW'(wa_q.size() - bw), 3);
    if (wa_q.size() - bw == 3) begin
      for (int r = 0; r < 3; r++) chk($sformatf("burst_waddr%0d", r), DW'(wa_q[bw + r]), DW'(r));
      chk("burst_rec2_b0", DW'(wd_q[bw + 2][7:0]), 8'h56);
    end
    chk("burst_wsize", DW'(wsize), 3);
    chk("burst_done", DW'(n_done - bd), 1);
    chk("burst_err", DW'(n_err - be), 0);

    // Reset mid-payload, then a fresh 2-record packet
    send(8'hA5); send(8'h02); send(8'h00);
    for (int i = 0; i < 30; i++) send(8'h77 + 8'(i));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", DW'(in_ready), 0);
    chk("mid_rst_wen", DW'(wen), 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_waddr", DW'(waddr), 0);
    chk("mid_rst_wsize", DW'(wsize), 0);
    chk("mid_rst_busy", DW'(busy), 0);
    chk("mid_rst_err_code", DW'(err_code), 0);
    reset = 1'b0;
    pause(1);
    bw = wa_q.size(); bd = n_done;
    send_pkt(2, 8'h05, 1'b0, 1, 1'b0, -1, 0);
    chk("post_rst_wen_count", DW'(wa_q.size() - bw), 2);
    if (wa_q.size() - bw == 2) begin
      chk("post_rst_waddr0", DW'(wa_q[bw]), 0);
      chk("post_rst_waddr1", DW'(wa_q[bw + 1]), 1);
    end
    chk("post_rst_wsize", DW'(wsize), 2);
    chk("post_rst_done", DW'(n_done - bd), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
